// File: rtl/mips_bus_initiator.sv
// Load/store front end of the MIPS core: one core memory request becomes one
// word-aligned Avalon-style bus transaction with lane steering and load extension.
module mips_bus_initiator #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    localparam int unsigned LW = $clog2(READ_LATENCY + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CMD    = 2'd1;
    localparam logic [1:0] S_RDWAIT = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]    state;
    logic          is_write;
    logic          is_signed;
    logic [1:0]    size_q;
    logic [1:0]    off_q;
    logic [LW-1:0] lat_cnt;
    logic [TW-1:0] wait_cnt;

    logic          req_bad;
    logic [3:0]    be_next;
    logic [31:0]   wd_next;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_data;

    // Bus command and response strobes decode straight from registered state,
    // so an asynchronous reset removes them in the same instant.
    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign read       = (state == S_CMD) && !is_write;
    assign write      = (state == S_CMD) && is_write;

    always_comb begin
        req_bad = 1'b0;
        be_next = 4'b1111;
        wd_next = req_wdata;
        case (req_size)
            2'd0: begin
                be_next = 4'b0001 << req_addr[1:0];
                wd_next = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                req_bad = req_addr[0];
                be_next = 4'b0011 << req_addr[1:0];
                wd_next = {2{req_wdata[15:0]}};
            end
            2'd2: begin
                req_bad = (req_addr[1:0] != 2'b00);
            end
            default: begin
                req_bad = 1'b1;
            end
        endcase
    end

    always_comb begin
        rd_byte   = readdata[{off_q, 3'b000} +: 8];
        rd_half   = readdata[{off_q[1], 4'b0000} +: 16];
        load_data = readdata;
        case (size_q)
            2'd0:    load_data = {{24{is_signed & rd_byte[7]}}, rd_byte};
            2'd1:    load_data = {{16{is_signed & rd_half[15]}}, rd_half};
            default: load_data = readdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            is_write   <= 1'b0;
            is_signed  <= 1'b0;
            size_q     <= '0;
            off_q      <= '0;
            lat_cnt    <= '0;
            wait_cnt   <= '0;
            address    <= '0;
            byteenable <= '0;
            writedata  <= '0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        is_write   <= req_write;
                        is_signed  <= req_signed;
                        size_q     <= req_size;
                        off_q      <= req_addr[1:0];
                        address    <= {req_addr[31:2], 2'b00};
                        byteenable <= be_next;
                        writedata  <= wd_next;
                        resp_rdata <= '0;
                        resp_error <= req_bad;
                        wait_cnt   <= '0;
                        state      <= req_bad ? S_RESP : S_CMD;
                    end
                end
                S_CMD: begin
                    if (!waitrequest) begin
                        lat_cnt <= LW'(READ_LATENCY);
                        state   <= is_write ? S_RESP : S_RDWAIT;
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        resp_error <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                S_RDWAIT: begin
                    // readdata is valid in the cycle where the count reaches one
                    if (lat_cnt == LW'(1)) begin
                        resp_rdata <= load_data;
                        state      <= S_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - LW'(1);
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
